event_trigger_mapper: RTL and testbench

- Upstream neighbour of the per-output pulse/pattern drivers, in the EVR clock domain.
- Each received event code is looked up in a 256-entry mapping table. The lookup produces a one-cycle trigger strobe on every output whose bit is set for that code.
- Each output has a programmable holdoff that suppresses re-triggering, plus a sticky flag recording suppressed triggers.
- The table and controls are written from registers already synchronised into evrClk.

---
 rtl/event_trigger_mapper.sv | 86 ++++++++
 tb/tb_event_trigger_mapper.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/event_trigger_mapper.sv
// Event-code to trigger-output mapper: 256-entry mask table lookup, 2-clock pipeline,
// per-output holdoff with sticky suppression flags. Runs entirely in the EVR clock domain.
module event_trigger_mapper #(
   parameter int unsigned NUM_OUTPUTS   = 8,
   parameter int unsigned EVCODE_WIDTH  = 8,
   parameter int unsigned HOLDOFF_WIDTH = 16
) (
   input  logic                     evrClk,
   input  logic                     resetN,
   input  logic [EVCODE_WIDTH-1:0]  evCode,
   input  logic                     evCodeValid,
   input  logic                     mapWriteStrobe,
   input  logic [EVCODE_WIDTH-1:0]  mapWriteAddr,
   input  logic [NUM_OUTPUTS-1:0]   mapWriteData,
   input  logic [NUM_OUTPUTS-1:0]   outputEnable,
   input  logic [HOLDOFF_WIDTH-1:0] holdoffCycles,
   input  logic [NUM_OUTPUTS-1:0]   clearSuppressed,
   output logic [NUM_OUTPUTS-1:0]   triggerStrobes,
   output logic [NUM_OUTPUTS-1:0]   suppressedFlags
);

   localparam int unsigned DEPTH = 2 ** EVCODE_WIDTH;

   logic [NUM_OUTPUTS-1:0]   map_ram [DEPTH];
   logic [NUM_OUTPUTS-1:0]   rd_mask;
   logic [NUM_OUTPUTS-1:0]   s2_mask;
   logic                     s1_valid;
   logic                     s2_valid;
   logic [NUM_OUTPUTS-1:0]   candidate;
   logic [NUM_OUTPUTS-1:0]   strobe_nxt;
   logic [NUM_OUTPUTS-1:0]   flag_nxt;
   logic [HOLDOFF_WIDTH-1:0] hc     [NUM_OUTPUTS];
   logic [HOLDOFF_WIDTH-1:0] hc_nxt [NUM_OUTPUTS];

   // Block RAM, read-first; contents deliberately survive reset.
   always_ff @(posedge evrClk) begin
      if (mapWriteStrobe) map_ram[mapWriteAddr] <= mapWriteData;
      rd_mask <= map_ram[evCode];
   end

   // Null code 0 is dropped here so it can never reach the outputs.
   always_ff @(posedge evrClk or negedge resetN) begin
      if (!resetN) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s2_mask  <= '0;
      end else begin
         s1_valid <= evCodeValid && (evCode != '0);
         s2_valid <= s1_valid;
         s2_mask  <= rd_mask;
      end
   end

   assign candidate = {NUM_OUTPUTS{s2_valid}} & s2_mask & outputEnable;

   // Holdoff: load at strobe, count down to zero, suppress candidates while nonzero.
   always_comb begin
      strobe_nxt = '0;
      flag_nxt   = suppressedFlags & ~clearSuppressed;
      hc_nxt     = hc;
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
         if (candidate[i] && (hc[i] == '0)) begin
            strobe_nxt[i] = 1'b1;
            hc_nxt[i]     = holdoffCycles;
         end else if (candidate[i]) begin
            flag_nxt[i]   = 1'b1;
            hc_nxt[i]     = hc[i] - HOLDOFF_WIDTH'(1);
         end else if (hc[i] != '0) begin
            hc_nxt[i]     = hc[i] - HOLDOFF_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge evrClk or negedge resetN) begin
      if (!resetN) begin
         triggerStrobes  <= '0;
         suppressedFlags <= '0;
         for (int unsigned i = 0; i < NUM_OUTPUTS; i++) hc[i] <= '0;
      end else begin
         triggerStrobes  <= strobe_nxt;
         suppressedFlags <= flag_nxt;
         for (int unsigned i = 0; i < NUM_OUTPUTS; i++) hc[i] <= hc_nxt[i];
      end
   end

endmodule

// File: tb/tb_event_trigger_mapper.sv
// Directed bench for event_trigger_mapper: table lookup, null code, holdoff/suppression,
// read-first write collision, output enables and reset flush.
module tb_event_trigger_mapper;

   logic        evrClk = 1'b0;
   logic        resetN;
   logic [7:0]  evCode;
   logic        evCodeValid;
   logic        mapWriteStrobe;
   logic [7:0]  mapWriteAddr;
   logic [7:0]  mapWriteData;
   logic [7:0]  outputEnable;
   logic [15:0] holdoffCycles;
   logic [7:0]  clearSuppressed;
   logic [7:0]  triggerStrobes;
   logic [7:0]  suppressedFlags;

   int n_checks = 0;
   int n_errors = 0;

   event_trigger_mapper #(
      .NUM_OUTPUTS(8), .EVCODE_WIDTH(8), .HOLDOFF_WIDTH(16)
   ) dut (
      .evrClk(evrClk), .resetN(resetN), .evCode(evCode), .evCodeValid(evCodeValid),
      .mapWriteStrobe(mapWriteStrobe), .mapWriteAddr(mapWriteAddr),
      .mapWriteData(mapWriteData), .outputEnable(outputEnable),
      .holdoffCycles(holdoffCycles), .clearSuppressed(clearSuppressed),
      .triggerStrobes(triggerStrobes), .suppressedFlags(suppressedFlags)
   );

   always #5 evrClk = ~evrClk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge evrClk);
      #1;
   endtask

   task automatic write_map(input logic [7:0] addr, input logic [7:0] data);
      mapWriteStrobe = 1'b1;
      mapWriteAddr   = addr;
      mapWriteData   = data;
      tick();
      mapWriteStrobe = 1'b0;
   endtask

   logic [7:0] pattern;

   initial begin
      resetN = 1'b0; evCode = '0; evCodeValid = 1'b0;
      mapWriteStrobe = 1'b0; mapWriteAddr = '0; mapWriteData = '0;
      outputEnable = 8'hFF; holdoffCycles = '0; clearSuppressed = '0;
      #2;
      repeat (3) tick();
      check("reset_strobes", 32'(triggerStrobes), 32'h0);
      check("reset_flags", 32'(suppressedFlags), 32'h0);
      resetN = 1'b1;
      tick();

      for (int a = 0; a < 256; a++) write_map(8'(a), 8'h00);

      // Single mapped event: strobe 0x05 for one cycle, two clocks after sampling.
      write_map(8'h28, 8'h05);
      evCode = 8'h28; evCodeValid = 1'b1;
      tick();
      evCodeValid = 1'b0;
      check("lat_k", 32'(triggerStrobes), 32'h0);
      tick();
      check("lat_k1", 32'(triggerStrobes), 32'h0);
      tick();
      check("lat_k2", 32'(triggerStrobes), 32'h05);
      tick();
      check("lat_k3", 32'(triggerStrobes), 32'h0);

      // Null code never triggers even with a full mask in entry 0.
      write_map(8'h00, 8'hFF);
      evCode = 8'h00; evCodeValid = 1'b1;
      tick();
      evCodeValid = 1'b0;
      pattern = '0;
      for (int i = 0; i < 4; i++) begin
         pattern = pattern | triggerStrobes;
         tick();
      end
      check("null_strobes", 32'(pattern), 32'h0);
      check("null_flags", 32'(suppressedFlags), 32'h0);

      // Holdoff 2 with six back-to-back events: strobes at stage-3 edges 2 and 5.
      holdoffCycles = 16'd2;
      write_map(8'h10, 8'h01);
      evCode = 8'h10;
      pattern = '0;
      for (int i = 0; i < 8; i++) begin
         evCodeValid = (i < 6);
         tick();
         pattern[i] = triggerStrobes[0];
      end
      evCodeValid = 1'b0;
      check("holdoff_pattern", 32'(pattern), 32'h24);
      check("holdoff_flag_set", 32'(suppressedFlags), 32'h01);
      clearSuppressed = 8'h01;
      tick();
      clearSuppressed = 8'h00;
      check("holdoff_flag_clr", 32'(suppressedFlags), 32'h0);

      // Holdoff 0: every candidate strobes.
      holdoffCycles = 16'd0;
      pattern = '0;
      for (int i = 0; i < 6; i++) begin
         evCodeValid = (i < 3);
         tick();
         pattern[i] = triggerStrobes[0];
      end
      evCodeValid = 1'b0;
      check("holdoff0_pattern", 32'(pattern), 32'h1C);
      check("holdoff0_flags", 32'(suppressedFlags), 32'h0);

      // Write and lookup of the same code on one edge returns the old entry.
      write_map(8'h30, 8'h01);
      mapWriteStrobe = 1'b1; mapWriteAddr = 8'h30; mapWriteData = 8'h02;
      evCode = 8'h30; evCodeValid = 1'b1;
      tick();
      mapWriteStrobe = 1'b0;
      tick();
      evCodeValid = 1'b0;
      tick();
      check("rdfirst_old", 32'(triggerStrobes), 32'h01);
      tick();
      check("rdfirst_new", 32'(triggerStrobes), 32'h02);
      tick();
      check("rdfirst_idle", 32'(triggerStrobes), 32'h0);

      // Output 0 disabled: no strobe and no flag; output 1 gets suppressed by holdoff.
      outputEnable = 8'hFE;
      holdoffCycles = 16'd3;
      write_map(8'h40, 8'h03);
      evCode = 8'h40; evCodeValid = 1'b1;
      tick();
      tick();
      evCodeValid = 1'b0;
      tick();
      check("enable_strobe", 32'(triggerStrobes), 32'h02);
      tick();
      check("enable_second", 32'(triggerStrobes), 32'h0);
      check("enable_flags", 32'(suppressedFlags), 32'h02);
      clearSuppressed = 8'hFF;
      tick();
      clearSuppressed = 8'h00;
      check("enable_flags_clr", 32'(suppressedFlags), 32'h0);
      outputEnable = 8'hFF;
      holdoffCycles = 16'd0;
      repeat (5) tick();

      // Reset while an event is in flight flushes it; table survives reset.
      evCode = 8'h28; evCodeValid = 1'b1;
      tick();
      evCodeValid = 1'b0;
      tick();
      resetN = 1'b0;
      #1;
      check("rst_async", 32'(triggerStrobes), 32'h0);
      tick();
      check("rst_flush", 32'(triggerStrobes), 32'h0);
      resetN = 1'b1;
      pattern = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         pattern = pattern | triggerStrobes;
      end
      check("rst_no_strobe", 32'(pattern), 32'h0);
      evCodeValid = 1'b1;
      tick();
      evCodeValid = 1'b0;
      tick();
      tick();
      check("rst_table_kept", 32'(triggerStrobes), 32'h05);
      tick();
      check("rst_table_idle", 32'(triggerStrobes), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
